// File: rtl/search_conntb_if.sv
// Purpose: bundles the lookup request/result handshake and the hashTb, flowKTb and free-flowID ports.
// Latency: none; wires only.
// Backpressure: key_in_valid/key_in_ready handshake on the request; results and RAM reads are strobes.
// Ports (modports): master = lookup engine side, slave = parser/RAM/configurer side.
interface search_conntb_if #(
  parameter int W_KEY     = 104,
  parameter int W_FLOWID  = 16,
  parameter int D_HASHTB  = 10,
  parameter int W_HASHTB  = 17,
  parameter int D_FLOWKTB = 10,
  parameter int W_FLOWKTB = 120
);
  logic                 conf_ready;
  logic                 key_in_valid;
  logic [W_KEY-1:0]     key_in;
  logic                 key_in_ready;
  logic                 result_valid;
  logic                 result_hit;
  logic                 result_new;
  logic [W_FLOWID-1:0]  result_flowID;
  logic                 result_overflow;
  logic [D_HASHTB-1:0]  idx_hashTb;
  logic                 rdValid_hashTb;
  logic [W_HASHTB-1:0]  ctx_hashTb;
  logic [D_FLOWKTB-1:0] idx_flowKTb;
  logic                 rdValid_flowKTb;
  logic [W_FLOWKTB-1:0] ctx_flowKTb;
  logic                 pull_freeFlowID_enable;
  logic [W_FLOWID-1:0]  free_flowID;
  logic                 add_conn_valid;
  logic [W_FLOWKTB-1:0] add_conn_info;

  modport master (
    input  conf_ready, key_in_valid, key_in, ctx_hashTb, ctx_flowKTb, free_flowID,
    output key_in_ready, result_valid, result_hit, result_new, result_flowID, result_overflow,
           idx_hashTb, rdValid_hashTb, idx_flowKTb, rdValid_flowKTb,
           pull_freeFlowID_enable, add_conn_valid, add_conn_info
  );

  modport slave (
    output conf_ready, key_in_valid, key_in, ctx_hashTb, ctx_flowKTb, free_flowID,
    input  key_in_ready, result_valid, result_hit, result_new, result_flowID, result_overflow,
           idx_hashTb, rdValid_hashTb, idx_flowKTb, rdValid_flowKTb,
           pull_freeFlowID_enable, add_conn_valid, add_conn_info
  );
endinterface

// File: rtl/search_conntb.sv
// Purpose: maps a 5-tuple to a flowID via hashTb and the flowKTb hash chain; optional auto-add on miss.
// Latency: hashTb miss 5 cycles, head hit 8, +3 per extra hop; auto-add adds 2 to a miss, bypass hit 2.
// Backpressure: key_in_ready only in IDLE with conf_ready; one lookup in flight at a time.
// Ports: clk, reset (active-low, synchronous); bus = search_conntb_if.master (request, result,
//   hashTb/flowKTb read ports, free-flowID pop, add-connection request).
// Option: define SEARCH_AUTO_ADD_EN to allocate a flowID and request an add on every miss.
module search_conntb #(
  parameter int W_KEY     = 104,
  parameter int W_FLOWID  = 16,
  parameter int D_HASHTB  = 10,
  parameter int W_HASHTB  = 17,
  parameter int D_FLOWKTB = 10,
  parameter int W_FLOWKTB = 120,
  parameter int MAX_CHAIN = 8
) (
  input  logic            clk,
  input  logic            reset,
  search_conntb_if.master bus
);
  localparam int W_HOP = $clog2(MAX_CHAIN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HASH, S_W1, S_W2, S_CHK_HASH, S_W1K, S_W2K, S_CHK_KEY, S_ALLOC, S_ADD, S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [W_KEY-1:0]     key_q, key_d;
  logic [W_FLOWID-1:0]  cur_q, cur_d;
  logic [W_HOP-1:0]     hop_q, hop_d;
  logic                 key_in_ready_q, key_in_ready_d;
  logic                 res_vld_q, res_vld_d;
  logic                 res_hit_q, res_hit_d;
  logic                 res_new_q, res_new_d;
  logic [W_FLOWID-1:0]  res_id_q, res_id_d;
  logic                 res_ovf_q, res_ovf_d;
  logic [D_HASHTB-1:0]  idx_hash_q, idx_hash_d;
  logic                 rd_hash_q, rd_hash_d;
  logic [D_FLOWKTB-1:0] idx_flowk_q, idx_flowk_d;
  logic                 rd_flowk_q, rd_flowk_d;

  logic                 miss, miss_ovf;
  logic                 hash_vld;
  logic [W_FLOWID-1:0]  head_id, next_id;
  logic [W_KEY-1:0]     ent_key;
  logic [D_HASHTB-1:0]  hash_idx;

  assign hash_vld = bus.ctx_hashTb[W_HASHTB-1];
  assign head_id  = bus.ctx_hashTb[W_FLOWID-1:0];
  assign ent_key  = bus.ctx_flowKTb[W_FLOWKTB-1:W_FLOWID];
  assign next_id  = bus.ctx_flowKTb[W_FLOWID-1:0];
  // XOR-fold of the low bits of srcIP, dstIP, srcPort and dstPort.
  assign hash_idx = key_q[0 +: D_HASHTB] ^ key_q[32 +: D_HASHTB] ^
                    key_q[64 +: D_HASHTB] ^ key_q[80 +: D_HASHTB];

`ifdef SEARCH_AUTO_ADD_EN
  logic                 ovf_q, ovf_d;
  logic                 pull_q, pull_d;
  logic                 add_vld_q, add_vld_d;
  logic [W_FLOWKTB-1:0] add_info_q, add_info_d;
  // Last allocation: covers the window before the configurer has written the tables.
  logic                 byp_vld_q, byp_vld_d;
  logic [W_KEY-1:0]     byp_key_q, byp_key_d;
  logic [W_FLOWID-1:0]  byp_id_q, byp_id_d;
  logic                 byp_hit;
  assign byp_hit = byp_vld_q && (key_q == byp_key_q);
`else
  logic unused_free_id;
  assign unused_free_id = ^bus.free_flowID;
`endif

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    cur_d       = cur_q;
    hop_d       = hop_q;
    res_vld_d   = 1'b0;
    res_hit_d   = res_hit_q;
    res_new_d   = res_new_q;
    res_id_d    = res_id_q;
    res_ovf_d   = res_ovf_q;
    idx_hash_d  = idx_hash_q;
    rd_hash_d   = 1'b0;
    idx_flowk_d = idx_flowk_q;
    rd_flowk_d  = 1'b0;
    miss        = 1'b0;
    miss_ovf    = 1'b0;
`ifdef SEARCH_AUTO_ADD_EN
    ovf_d       = ovf_q;
    pull_d      = 1'b0;
    add_vld_d   = 1'b0;
    add_info_d  = add_info_q;
    byp_vld_d   = byp_vld_q;
    byp_key_d   = byp_key_q;
    byp_id_d    = byp_id_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.key_in_valid && key_in_ready_q) begin
          key_d   = bus.key_in;
          state_d = S_HASH;
        end
      end
      S_HASH: begin
`ifdef SEARCH_AUTO_ADD_EN
        if (byp_hit) begin
          res_vld_d = 1'b1;
          res_hit_d = 1'b1;
          res_new_d = 1'b0;
          res_id_d  = byp_id_q;
          res_ovf_d = 1'b0;
          state_d   = S_RESP;
        end else
`endif
        begin
          idx_hash_d = hash_idx;
          rd_hash_d  = 1'b1;
          state_d    = S_W1;
        end
      end
      S_W1:  state_d = S_W2;
      S_W2:  state_d = S_CHK_HASH;
      S_CHK_HASH: begin
        if (!hash_vld) begin
          miss = 1'b1;
        end else begin
          idx_flowk_d = head_id[D_FLOWKTB-1:0];
          rd_flowk_d  = 1'b1;
          cur_d       = head_id;
          hop_d       = W_HOP'(1);
          state_d     = S_W1K;
        end
      end
      S_W1K: state_d = S_W2K;
      S_W2K: state_d = S_CHK_KEY;
      S_CHK_KEY: begin
        if (ent_key == key_q) begin
          res_vld_d = 1'b1;
          res_hit_d = 1'b1;
          res_new_d = 1'b0;
          res_id_d  = cur_q;
          res_ovf_d = 1'b0;
          state_d   = S_RESP;
        end else if (next_id == '0) begin
          miss = 1'b1;
        end else if (hop_q == W_HOP'(MAX_CHAIN)) begin
          miss     = 1'b1;
          miss_ovf = 1'b1;
        end else begin
          idx_flowk_d = next_id[D_FLOWKTB-1:0];
          rd_flowk_d  = 1'b1;
          cur_d       = next_id;
          hop_d       = hop_q + W_HOP'(1);
          state_d     = S_W1K;
        end
      end
`ifdef SEARCH_AUTO_ADD_EN
      // The pop strobe is visible during ALLOC; the FIFO head is taken one cycle later in ADD.
      S_ALLOC: state_d = S_ADD;
      S_ADD: begin
        add_vld_d  = 1'b1;
        add_info_d = {key_q, bus.free_flowID};
        byp_vld_d  = 1'b1;
        byp_key_d  = key_q;
        byp_id_d   = bus.free_flowID;
        res_vld_d  = 1'b1;
        res_hit_d  = 1'b0;
        res_new_d  = 1'b1;
        res_id_d   = bus.free_flowID;
        res_ovf_d  = ovf_q;
        state_d    = S_RESP;
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (miss) begin
`ifdef SEARCH_AUTO_ADD_EN
      ovf_d   = miss_ovf;
      pull_d  = 1'b1;
      state_d = S_ALLOC;
`else
      res_vld_d = 1'b1;
      res_hit_d = 1'b0;
      res_new_d = 1'b0;
      res_id_d  = '0;
      res_ovf_d = miss_ovf;
      state_d   = S_RESP;
`endif
    end

    key_in_ready_d = (state_d == S_IDLE) && bus.conf_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      key_q          <= '0;
      cur_q          <= '0;
      hop_q          <= '0;
      key_in_ready_q <= 1'b0;
      res_vld_q      <= 1'b0;
      res_hit_q      <= 1'b0;
      res_new_q      <= 1'b0;
      res_id_q       <= '0;
      res_ovf_q      <= 1'b0;
      idx_hash_q     <= '0;
      rd_hash_q      <= 1'b0;
      idx_flowk_q    <= '0;
      rd_flowk_q     <= 1'b0;
`ifdef SEARCH_AUTO_ADD_EN
      ovf_q          <= 1'b0;
      pull_q         <= 1'b0;
      add_vld_q      <= 1'b0;
      add_info_q     <= '0;
      byp_vld_q      <= 1'b0;
      byp_key_q      <= '0;
      byp_id_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      cur_q          <= cur_d;
      hop_q          <= hop_d;
      key_in_ready_q <= key_in_ready_d;
      res_vld_q      <= res_vld_d;
      res_hit_q      <= res_hit_d;
      res_new_q      <= res_new_d;
      res_id_q       <= res_id_d;
      res_ovf_q      <= res_ovf_d;
      idx_hash_q     <= idx_hash_d;
      rd_hash_q      <= rd_hash_d;
      idx_flowk_q    <= idx_flowk_d;
      rd_flowk_q     <= rd_flowk_d;
`ifdef SEARCH_AUTO_ADD_EN
      ovf_q          <= ovf_d;
      pull_q         <= pull_d;
      add_vld_q      <= add_vld_d;
      add_info_q     <= add_info_d;
      byp_vld_q      <= byp_vld_d;
      byp_key_q      <= byp_key_d;
      byp_id_q       <= byp_id_d;
`endif
    end
  end

  assign bus.key_in_ready    = key_in_ready_q;
  assign bus.result_valid    = res_vld_q;
  assign bus.result_hit      = res_hit_q;
  assign bus.result_new      = res_new_q;
  assign bus.result_flowID   = res_id_q;
  assign bus.result_overflow = res_ovf_q;
  assign bus.idx_hashTb      = idx_hash_q;
  assign bus.rdValid_hashTb  = rd_hash_q;
  assign bus.idx_flowKTb     = idx_flowk_q;
  assign bus.rdValid_flowKTb = rd_flowk_q;
`ifdef SEARCH_AUTO_ADD_EN
  assign bus.pull_freeFlowID_enable = pull_q;
  assign bus.add_conn_valid         = add_vld_q;
  assign bus.add_conn_info          = add_info_q;
`else
  assign bus.pull_freeFlowID_enable = 1'b0;
  assign bus.add_conn_valid         = 1'b0;
  assign bus.add_conn_info          = '0;
`endif
endmodule
